to_mon_transmitter: RTL and testbench

TO_MON_TRANSMITTER -- requirements
Module: to_mon_transmitter

---
 rtl/nextasic_pkg.sv | 6 +
 rtl/mon_pkt_fifo.sv | 40 ++++
 rtl/to_mon_transmitter.sv | 61 ++++++
 tb/tb_to_mon_transmitter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/nextasic_pkg.sv
// nextasic_pkg: shared packet width, transmitter state encoding and default gap length.
package nextasic_pkg;
    localparam int PKT_W = 40;
    localparam int DEF_IDLE_GAP = 4;
    typedef enum logic [1:0] {IDLE, START, DATA, GAP} tx_state_t;
endpackage

// File: rtl/mon_pkt_fifo.sv
// mon_pkt_fifo: power-of-two packet FIFO with registered occupancy count.
module mon_pkt_fifo import nextasic_pkg::*; #(
    parameter int W = PKT_W,
    parameter int DEPTH = 4
) (
    input  logic                     mon_clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign full = count == FULL_CNT;
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) mem[wr_ptr] <= din;
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/to_mon_transmitter.sv
// to_mon_transmitter: queues 40-bit packets and sends them serially as start bit, MSB-first data, idle gap.
module to_mon_transmitter import nextasic_pkg::*; #(
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_GAP = DEF_IDLE_GAP
) (
    input  logic             mon_clk,
    input  logic             reset,
    input  logic [PKT_W-1:0] pkt_data,
    input  logic             pkt_valid,
    output logic             pkt_ready,
    output logic             to_mon,
    output logic             busy,
    output logic             pkt_sent
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = $clog2(IDLE_GAP + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_GAP - 1);
    tx_state_t state, state_n;
    logic [PKT_W-1:0] shreg, head;
    logic [5:0] bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic [CW-1:0] count;
    logic pop, full, empty, last_bit, last_gap;
    mon_pkt_fifo #(.W(PKT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .mon_clk(mon_clk),
        .reset(reset),
        .push(pkt_valid && !full),
        .pop(pop),
        .din(pkt_data),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
    assign pkt_ready = count != FULL_CNT;
    assign busy = !empty || state != IDLE;
    assign pkt_sent = last_bit;
    always_comb begin
        last_bit = state == DATA && bit_cnt == 6'd39;
        last_gap = state == GAP && gap_cnt == GAP_LAST;
        pop = (state == IDLE || last_gap) && !empty;
        state_n = pop ? START : state == START ? DATA : last_bit ? GAP : last_gap ? IDLE : state;
    end
    // to_mon follows the next state so the line is fully registered
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            to_mon  <= 1'b1;
        end else begin
            state   <= state_n;
            shreg   <= pop ? head : state_n == DATA ? shreg << 1 : shreg;
            bit_cnt <= state == DATA ? bit_cnt + 6'd1 : '0;
            gap_cnt <= state == GAP ? gap_cnt + GW'(1) : '0;
            to_mon  <= state_n == START ? 1'b0 : state_n == DATA ? shreg[PKT_W-1] : 1'b1;
        end
    end
endmodule

// File: tb/tb_to_mon_transmitter.sv
// tb_to_mon_transmitter: scoreboard bench; a serial receiver model decodes to_mon and checks against accepted packets.
module tb_to_mon_transmitter;
    logic        mon_clk = 0;
    logic        reset = 1;
    logic [39:0] pkt_data = '0;
    logic        pkt_valid = 0;
    logic        pkt_ready, to_mon, busy, pkt_sent;

    int vectors = 0, fails = 0, cyc = 0;
    int frames = 0, sent_cnt = 0, nbit = 0, high_run = 0;
    int accepts = 0, stall_at = -1;
    bit in_frame = 0;
    logic [39:0] word;
    logic [39:0] exp_q[$];
    int starts[$];
    int gaps[$];

    to_mon_transmitter #(.FIFO_DEPTH(4), .IDLE_GAP(4)) dut (
        .mon_clk(mon_clk),
        .reset(reset),
        .pkt_data(pkt_data),
        .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready),
        .to_mon(to_mon),
        .busy(busy),
        .pkt_sent(pkt_sent)
    );

    always #5 mon_clk = ~mon_clk;
    always @(posedge mon_clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // receiver model: start bit, 40 bits MSB first, then compare with scoreboard head
    always @(negedge mon_clk) begin
        if (reset) begin
            in_frame = 0;
            nbit = 0;
            high_run = 0;
            exp_q.delete();
        end else if (!in_frame) begin
            if (to_mon === 1'b0) begin
                in_frame = 1;
                nbit = 0;
                starts.push_back(cyc);
                gaps.push_back(high_run);
            end else high_run++;
        end else begin
            word = {word[38:0], to_mon};
            nbit++;
            if (nbit == 40) begin
                in_frame = 0;
                high_run = 0;
                frames++;
                chk("pkt_sent_last_bit", 64'(pkt_sent), 64'd1);
                if (exp_q.size() == 0) chk("unexpected_frame", 64'(word), 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("frame_word", 64'(word), 64'(exp_q.pop_front()));
            end
        end
        if (!reset && pkt_sent) sent_cnt++;
    end

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [39:0] d);
        int guard = 0;
        logic r;
        pkt_data = d;
        pkt_valid = 1;
        forever begin
            r = pkt_ready;
            if (!r && stall_at < 0) stall_at = accepts;
            @(posedge mon_clk);
            if (r) begin
                exp_q.push_back(d);
                accepts++;
                break;
            end
            @(negedge mon_clk);
            if (++guard > 500) begin
                chk("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(negedge mon_clk);
        pkt_valid = 0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            @(negedge mon_clk);
            t++;
        end
        chk("drain_idle", 64'(t < 3000), 64'd1);
    endtask

    initial begin
        logic [39:0] pk [6];
        logic [63:0] rnd;
        pk[0] = 40'h12_3456_789A; pk[1] = 40'hFF_0000_00FF; pk[2] = 40'h80_0000_0001;
        pk[3] = 40'h55_AAAA_5555; pk[4] = 40'h00_FFFF_0000; pk[5] = 40'hDE_ADBE_EF01;
        repeat (2) @(negedge mon_clk);
        chk("rst_to_mon", 64'(to_mon), 64'd1);
        chk("rst_pkt_ready", 64'(pkt_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pkt_sent", 64'(pkt_sent), 64'd0);
        reset = 0;
        repeat (2) @(negedge mon_clk);

        send(40'hA5_0F00_1234);
        chk("latency_idle_after_accept", 64'(to_mon), 64'd1);
        chk("busy_after_accept", 64'(busy), 64'd1);
        @(negedge mon_clk);
        chk("latency_start_bit", 64'(to_mon), 64'd0);
        drain();
        chk("single_pulses", 64'(sent_cnt), 64'd1);

        repeat (3) @(negedge mon_clk);
        starts.delete();
        gaps.delete();
        for (int i = 0; i < 3; i++) send(pk[i]);
        drain();
        chk("b2b_frames", 64'(starts.size()), 64'd3);
        for (int i = 1; i < 3 && i < starts.size(); i++) begin
            chk("b2b_start_spacing", 64'(starts[i] - starts[i-1]), 64'd45);
            chk("b2b_gap_high", 64'(gaps[i]), 64'd4);
        end

        accepts = 0;
        stall_at = -1;
        for (int i = 0; i < 6; i++) send(pk[i]);
        chk("full_stall_after_accepts", 64'(stall_at), 64'd5);
        drain();

        send(40'hC3_1111_2222);
        send(40'h3C_3333_4444);
        for (int t = 0; t < 200 && !(in_frame && nbit >= 20); t++) @(negedge mon_clk);
        chk("reached_bit20", 64'(in_frame && nbit >= 20), 64'd1);
        reset = 1;
        @(negedge mon_clk);
        #1;
        chk("midrst_to_mon", 64'(to_mon), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_pkt_ready", 64'(pkt_ready), 64'd1);
        reset = 0;
        @(negedge mon_clk);
        send(40'h96_6969_0F0F);
        drain();

        for (int i = 0; i < 100; i++) begin
            rnd = {$urandom(), $urandom()};
            send(rnd[39:0]);
        end
        drain();

        chk("total_frames", 64'(frames), 64'd111);
        chk("pulse_count", 64'(sent_cnt), 64'(frames));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
